// File: rtl/bus_sram_responder_if.sv
// Initiator/responder bus bundle for bus_sram_responder.
interface bus_sram_responder_if;
  logic        beginTransactionIn;
  logic [31:0] addressDataIn;
  logic [3:0]  byteEnablesIn;
  logic [7:0]  burstSizeIn;
  logic        readNotWriteIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic        busyIn;
  logic [31:0] addressDataOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic        errorOut;

  modport slave (
    input  beginTransactionIn, addressDataIn, byteEnablesIn, burstSizeIn,
    input  readNotWriteIn, dataValidIn, endTransactionIn, busyIn,
    output addressDataOut, dataValidOut, endTransactionOut, errorOut
  );

  modport master (
    output beginTransactionIn, addressDataIn, byteEnablesIn, burstSizeIn,
    output readNotWriteIn, dataValidIn, endTransactionIn, busyIn,
    input  addressDataOut, dataValidOut, endTransactionOut, errorOut
  );
endinterface

// File: rtl/bus_sram_responder.sv
// Burst-capable SRAM responder with a 2^addrBits-word window at Base.
// Define BUS_SRAM_RESPONDER_ERROR_EN to answer near-miss addresses with an error.
module bus_sram_responder #(
  parameter logic [31:0] Base     = 32'h40000000,
  parameter int          addrBits = 9
) (
  input logic                 clock,
  input logic                 reset,
  bus_sram_responder_if.slave bus
);

  localparam int Depth = 1 << addrBits;
  localparam logic [addrBits-1:0] word_one = {{(addrBits-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    ERROR = 3'd3,
    END   = 3'd4
  } state_e;

  state_e              state_r, state_s;
  logic [addrBits-1:0] word_r, word_s;
  logic [8:0]          cnt_r, cnt_s;
  logic [3:0]          be_r, be_s;
  logic                valid_r, valid_s;
  logic                end_r, end_s;
  logic [31:0]         data_r;
  logic                fetch_s;
  logic                we_s;
  logic                win_hit_s;
  logic                err_hit_s;
  logic [31:0]         mem_r [Depth];

  assign win_hit_s = bus.beginTransactionIn &&
                     (bus.addressDataIn[31:addrBits+2] == Base[31:addrBits+2]);

`ifdef BUS_SRAM_RESPONDER_ERROR_EN
  logic err_r;

  assign err_hit_s = bus.beginTransactionIn && !win_hit_s &&
                     (bus.addressDataIn[31:addrBits+4] == Base[31:addrBits+4]);

  // one-cycle error flag raised together with the ERROR entry
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else begin
      err_r <= (state_r == IDLE) && err_hit_s;
    end
  end

  assign bus.errorOut = err_r;
`else
  assign err_hit_s    = 1'b0;
  assign bus.errorOut = 1'b0;
`endif

  // next-state and next-output decode
  always_comb begin
    state_s = state_r;
    word_s  = word_r;
    cnt_s   = cnt_r;
    be_s    = be_r;
    valid_s = 1'b0;
    end_s   = 1'b0;
    fetch_s = 1'b0;
    we_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (win_hit_s) begin
          word_s  = bus.addressDataIn[addrBits+1:2];
          cnt_s   = {1'b0, bus.burstSizeIn} + 9'd1;
          be_s    = (bus.burstSizeIn != 8'd0) ? 4'hF : bus.byteEnablesIn;
          state_s = bus.readNotWriteIn ? READ : WRITE;
        end else if (err_hit_s) begin
          end_s   = 1'b1;
          state_s = ERROR;
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (bus.endTransactionIn) begin
          state_s = IDLE;
        end else if (!valid_r || (!bus.busyIn && (cnt_r != 9'd0))) begin
          // first fetch, or current beat consumed with more to go
          fetch_s = 1'b1;
          valid_s = 1'b1;
          word_s  = word_r + word_one;
          cnt_s   = cnt_r - 9'd1;
        end else if (bus.busyIn) begin
          valid_s = 1'b1;
        end else begin
          end_s   = 1'b1;
          state_s = END;
        end
      end
      WRITE: begin
        if (bus.dataValidIn && (cnt_r != 9'd0) && !reset) begin
          we_s   = 1'b1;
          word_s = word_r + word_one;
          cnt_s  = cnt_r - 9'd1;
        end else begin
          we_s = 1'b0;
        end
        if (bus.endTransactionIn) begin
          state_s = IDLE;
        end else begin
          state_s = WRITE;
        end
      end
      ERROR:   state_s = IDLE;
      END:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // control state and registered handshake outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      word_r  <= {addrBits{1'b0}};
      cnt_r   <= 9'd0;
      be_r    <= 4'h0;
      valid_r <= 1'b0;
      end_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      word_r  <= word_s;
      cnt_r   <= cnt_s;
      be_r    <= be_s;
      valid_r <= valid_s;
      end_r   <= end_s;
    end
  end

  // read data register doubles as the synchronous memory output
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_r <= 32'h0;
    end else if (fetch_s) begin
      data_r <= mem_r[word_r];
    end else if (!valid_s) begin
      data_r <= 32'h0;
    end
  end

  // byte-lane write port; deliberately not reset so contents survive reset
  always_ff @(posedge clock) begin
    if (we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_r[i]) begin
          mem_r[word_r][8*i +: 8] <= bus.addressDataIn[8*i +: 8];
        end
      end
    end
  end

  assign bus.addressDataOut    = data_r;
  assign bus.dataValidOut      = valid_r;
  assign bus.endTransactionOut = end_r;

endmodule
